counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
- Sequencer for the board's 4-bit loadable JK counter datapath.
- Turns three raw active-low push buttons into clean commands: load, free-run and single-step. Button inputs are synchronised and debounced before use.
- Drives the counter's load strobe, load data and count-enable pulse.
- In one-shot mode, stops free-run when the counter value it reads back reaches a switch-selected terminal value.

Parameters:
- CNT_W, 4, counter width
- TICK_DIV, 25000000, clk cycles per run-mode count tick (2 Hz at 50 MHz)
- DEB_CYCLES, 1000000, cycles a synchronised key must stay stable before it is accepted (20 ms)

Ports:
- clk  in  1  system clock (50 MHz board clock)
- reset  in  1  synchronous, active-high reset
- key_load_n  in  1  raw button, 0 = pressed
- key_run_n  in  1  raw button, 0 = pressed; toggles run/stop
- key_step_n  in  1  raw button, 0 = pressed
- sw_d  in  CNT_W  value loaded into the counter
- sw_oneshot  in  1  1 = stop run at terminal value
- sw_term  in  CNT_W  terminal value
- cnt_q  in  CNT_W  current counter value read back
- cnt_load  out  1  one-cycle load strobe to the counter
- cnt_d  out  CNT_W  load data, valid while cnt_load=1
- cnt_en  out  1  one-cycle count-enable pulse
- state  out  2  FSM state, for LEDG
- done  out  1  sticky; set when a one-shot run has stopped

Behaviour:
- All outputs are registered.
- On the reset edge: cnt_load=0, cnt_d=0, cnt_en=0, state=IDLE(00), done=0.
- Also cleared on reset: prescaler, debounce counters, synchroniser flops (to 1 = released), debounced levels (1).
- Key path, per key:
  - 2-flop synchroniser, then a stability counter.
  - The debounced level updates only after DEB_CYCLES consecutive equal samples.
  - A 1→0 transition of the debounced level gives a one-cycle press pulse. Release gives no pulse.
  - A held key gives exactly one pulse.
- States: IDLE=00, RUN=01, LOAD=10, STEP=11.
- IDLE, on press pulses, priority load > run > step; lower-priority pulses arriving in the same cycle are dropped:
  - load → LOAD: same edge sets cnt_load←1, cnt_d←sw_d, done←0.
  - run → RUN: clears prescaler, done←0.
  - step → STEP: cnt_en←1, done←0.
- LOAD: one cycle, then → IDLE with cnt_load←0. cnt_d holds its value.
- STEP: one cycle, then → IDLE with cnt_en←0.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; the tick fires when it wraps. The first tick comes TICK_DIV cycles after entering RUN.
  - On a tick with no stop condition: cnt_en←1 for one cycle.
  - Stop condition = sw_oneshot=1 and cnt_q==sw_term, sampled on the tick cycle. When it holds: no cnt_en, → IDLE, done←1.
  - Run press → IDLE; no cnt_en that cycle even if a tick coincides.
  - Load press → LOAD (then IDLE); it has priority over run press and over the tick.
  - Step press is ignored.
- sw_oneshot=0: RUN continues through the CNT_W wrap (F→0) indefinitely.
- cnt_q==sw_term on entry to RUN in one-shot mode: stops at the first tick with zero cnt_en pulses and done=1.
- done stays set until the next accepted load/run/step command or reset.
- Reset asserted mid-operation wins over everything. Outputs return to reset values on that edge, and a pending press pulse is lost.
- sw_* are sampled only on the edges described above; no synchronisation is required (quasi-static switches).

Decomposition:
- Shared header/package counter_seq_defs:
  - State codes ST_IDLE, ST_RUN, ST_LOAD, ST_STEP.
  - Default TICK_DIV and DEB_CYCLES constants.
  - Prescaler and debounce counter widths, derived via $clog2.
- Sub-module key_debounce(clk, reset, key_n, press): synchroniser, stability counter and press-pulse generator, parameterised by DEB_CYCLES. Instantiated three times.
- Top module: FSM, prescaler, output registers.

Test Plan:
Bench uses TICK_DIV=4, DEB_CYCLES=3, and a behavioural 4-bit counter model driven by cnt_load/cnt_d/cnt_en feeding cnt_q.
- Reset: hold reset 2 cycles with all keys released → cnt_load=0, cnt_en=0, cnt_d=0, state=00, done=0. No pulses for 20 cycles after release.
- Bounce: sw_d=4'hA; key_load_n toggles every cycle for 10 cycles, then held 0 for 10 cycles → exactly one cnt_load pulse, cnt_d=A, state passes 10→00, model counter=A.
- Free run: load 4'hE, then press run, sw_oneshot=0 → cnt_en every 4th cycle, counter E,F,0,1. Press run again → state=00, no further cnt_en.
- One-shot: load 0, sw_oneshot=1, sw_term=3, press run → exactly 3 cnt_en pulses. Then state=00, done=1, counter=3. A subsequent step press clears done and gives counter=4.
- Simultaneous: in IDLE, key_load_n and key_run_n released to pressed on the same cycle → one cnt_load pulse, then state=00. Run not entered, no cnt_en.
- Reset mid-RUN: assert reset the cycle before a tick → no cnt_en, state=00 on that edge. After release, a run press gives its first cnt_en 4 cycles after RUN entry.

Source files
------------

// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencer: state codes, default
// timing constants and counter-width helpers.
package counter_seq_defs;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_LOAD = 2'b10;
  localparam logic [1:0] ST_STEP = 2'b11;

  // 2 Hz run tick and 20 ms debounce window at the 50 MHz board clock
  localparam int TICK_DIV_DEF   = 25000000;
  localparam int DEB_CYCLES_DEF = 1000000;

  // Width of a counter that must hold 0..n-1 (never narrower than 1 bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PRESC_W_DEF = cnt_width(TICK_DIV_DEF);
  localparam int DEB_W_DEF   = cnt_width(DEB_CYCLES_DEF);

endpackage

// File: rtl/counter_seq_ctrl_key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on each accepted release-to-press transition.
module key_debounce
  import counter_seq_defs::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int              DEB_W    = cnt_width(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [DEB_W-1:0] stab_q, stab_d;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the window, so bounces never get through.
  always_comb begin
    stab_d  = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (stab_q == DEB_LAST) begin
        level_d = sync2_q;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
    press_d = level_q & ~level_d;
  end

  // Synchroniser and debounce state; everything idles as "released"
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      stab_q  <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      stab_q  <= stab_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for the 4-bit loadable counter: turns debounced button presses
// into load / step / free-run commands and stops one-shot runs at a
// switch-selected terminal value.
module counter_seq_ctrl
  import counter_seq_defs::*;
#(
  parameter int CNT_W      = 4,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_load_n,
  input  logic             key_run_n,
  input  logic             key_step_n,
  input  logic [CNT_W-1:0] sw_d,
  input  logic             sw_oneshot,
  input  logic [CNT_W-1:0] sw_term,
  input  logic [CNT_W-1:0] cnt_q,
  output logic             cnt_load,
  output logic [CNT_W-1:0] cnt_d,
  output logic             cnt_en,
  output logic [1:0]       state,
  output logic             done
);

  localparam int                PRESC_W    = cnt_width(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic press_load, press_run, press_step;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk(clk), .reset(reset), .key_n(key_load_n), .press(press_load)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk(clk), .reset(reset), .key_n(key_run_n), .press(press_run)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk(clk), .reset(reset), .key_n(key_step_n), .press(press_step)
  );

  logic [1:0]         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               cnt_load_q, cnt_load_d;
  logic [CNT_W-1:0]   cnt_d_q, cnt_d_d;
  logic               cnt_en_q, cnt_en_d;
  logic               done_q, done_d;
  logic               tick;

  // Next-state and output decode; strobes default low so they last one cycle
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cnt_load_d = 1'b0;
    cnt_d_d    = cnt_d_q;
    cnt_en_d   = 1'b0;
    done_d     = done_q;
    tick       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Load beats run beats step; losers in the same cycle are dropped
        if (press_load) begin
          state_d    = ST_LOAD;
          cnt_load_d = 1'b1;
          cnt_d_d    = sw_d;
          done_d     = 1'b0;
        end else if (press_run) begin
          state_d = ST_RUN;
          presc_d = '0;
          done_d  = 1'b0;
        end else if (press_step) begin
          state_d  = ST_STEP;
          cnt_en_d = 1'b1;
          done_d   = 1'b0;
        end
      end
      ST_RUN: begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (press_load) begin
          state_d    = ST_LOAD;
          cnt_load_d = 1'b1;
          cnt_d_d    = sw_d;
          done_d     = 1'b0;
        end else if (press_run) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (sw_oneshot && (cnt_q == sw_term)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_en_d = 1'b1;
          end
        end
      end
      default: begin
        // LOAD and STEP last exactly one cycle
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, prescaler and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      cnt_load_q <= 1'b0;
      cnt_d_q    <= '0;
      cnt_en_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_load_q <= cnt_load_d;
      cnt_d_q    <= cnt_d_d;
      cnt_en_q   <= cnt_en_d;
      done_q     <= done_d;
    end
  end

  assign cnt_load = cnt_load_q;
  assign cnt_d    = cnt_d_q;
  assign cnt_en   = cnt_en_q;
  assign state    = state_q;
  assign done     = done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: directed key stimulus, a behavioural counter
// closing the loop, and a scoreboard of expected load/count pulses.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_load_n = 1'b1;
  logic       key_run_n = 1'b1;
  logic       key_step_n = 1'b1;
  logic [3:0] sw_d = 4'h0;
  logic       sw_oneshot = 1'b0;
  logic [3:0] sw_term = 4'h0;
  logic [3:0] cnt_q;
  logic       cnt_load;
  logic [3:0] cnt_d;
  logic       cnt_en;
  logic [1:0] state;
  logic       done;

  counter_seq_ctrl #(.CNT_W(4), .TICK_DIV(4), .DEB_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .key_load_n(key_load_n), .key_run_n(key_run_n), .key_step_n(key_step_n),
    .sw_d(sw_d), .sw_oneshot(sw_oneshot), .sw_term(sw_term), .cnt_q(cnt_q),
    .cnt_load(cnt_load), .cnt_d(cnt_d), .cnt_en(cnt_en),
    .state(state), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural counter datapath
  logic [3:0] model_cnt = 4'h0;
  always @(posedge clk) begin
    if (cnt_load)    model_cnt <= cnt_d;
    else if (cnt_en) model_cnt <= model_cnt + 4'h1;
  end
  assign cnt_q = model_cnt;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_en;
    logic [3:0] val;       // cnt_d for a load, counter value before a count
    int         gap;       // required cycles since reference, 0 = any
    bit         from_run;  // reference is RUN entry instead of previous count
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit is_en, input logic [3:0] val,
                          input int gap, input bit from_run);
    exp_t e;
    e.is_en = is_en; e.val = val; e.gap = gap; e.from_run = from_run;
    exp_q.push_back(e);
  endtask

  task automatic wait_state(input logic [1:0] exp, input int maxc, input string name);
    int n = 0;
    while (state !== exp && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(state), int'(exp));
  endtask

  // Monitor: every load or count pulse must match the head of the scoreboard
  initial begin
    int         run_cyc = 0;
    int         last_en = 0;
    logic [1:0] prev_state = 2'b00;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (state == 2'b01 && prev_state != 2'b01) run_cyc = cyc;
      if (cnt_load || cnt_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got load=%0d en=%0d d=%0h cnt=%0h, expected none (t=%0t)",
                   cnt_load, cnt_en, cnt_d, model_cnt, $time);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", int'(cnt_en), int'(e.is_en));
          check("pulse_value", cnt_en ? int'(model_cnt) : int'(cnt_d), int'(e.val));
          if (e.gap != 0)
            check("pulse_spacing", e.from_run ? cyc - run_cyc : cyc - last_en, e.gap);
        end
        if (cnt_en) last_en = cyc;
      end
      prev_state = state;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;

    // Reset with all keys released
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cnt_load", int'(cnt_load), 0);
    check("rst_cnt_en", int'(cnt_en), 0);
    check("rst_cnt_d", int'(cnt_d), 0);
    check("rst_state", int'(state), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (state != 2'b00) bad++;
    end
    check("idle_after_reset", bad, 0);

    // Bouncing load key: only the settled press is accepted
    sw_d = 4'hA;
    push_exp(1'b0, 4'hA, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      key_load_n = ~key_load_n;
      @(negedge clk);
    end
    key_load_n = 1'b0;
    wait_state(2'b10, 20, "bounce_load_state");
    @(negedge clk);
    check("bounce_back_idle", int'(state), 0);
    repeat (10) @(negedge clk);
    key_load_n = 1'b1;
    repeat (15) @(negedge clk);
    check("bounce_cnt_d_held", int'(cnt_d), 'hA);
    check("bounce_counter", int'(model_cnt), 'hA);

    // Free run from E through the wrap, stopped by a second run press
    sw_d = 4'hE;
    push_exp(1'b0, 4'hE, 0, 1'b0);
    key_load_n = 1'b0;
    wait_state(2'b10, 20, "fr_load_state");
    key_load_n = 1'b1;
    repeat (10) @(negedge clk);
    sw_oneshot = 1'b0;
    push_exp(1'b1, 4'hE, 4, 1'b1);
    push_exp(1'b1, 4'hF, 4, 1'b0);
    push_exp(1'b1, 4'h0, 4, 1'b0);
    push_exp(1'b1, 4'h1, 4, 1'b0);
    key_run_n = 1'b0;
    wait_state(2'b01, 20, "fr_run_state");
    key_run_n = 1'b1;
    repeat (12) @(negedge clk);
    key_run_n = 1'b0;
    wait_state(2'b00, 20, "fr_stop_state");
    key_run_n = 1'b1;
    repeat (20) @(negedge clk);
    check("fr_pending", exp_q.size(), 0);
    check("fr_counter", int'(model_cnt), 2);

    // One-shot: load 0, stop at 3
    sw_d = 4'h0;
    push_exp(1'b0, 4'h0, 0, 1'b0);
    key_load_n = 1'b0;
    wait_state(2'b10, 20, "os_load_state");
    key_load_n = 1'b1;
    repeat (10) @(negedge clk);
    sw_oneshot = 1'b1;
    sw_term = 4'h3;
    push_exp(1'b1, 4'h0, 4, 1'b1);
    push_exp(1'b1, 4'h1, 4, 1'b0);
    push_exp(1'b1, 4'h2, 4, 1'b0);
    key_run_n = 1'b0;
    wait_state(2'b01, 20, "os_run_state");
    key_run_n = 1'b1;
    wait_state(2'b00, 40, "os_stop_state");
    check("os_done", int'(done), 1);
    check("os_counter", int'(model_cnt), 3);
    check("os_pending", exp_q.size(), 0);
    repeat (10) @(negedge clk);
    check("os_done_sticky", int'(done), 1);
    push_exp(1'b1, 4'h3, 0, 1'b0);
    key_step_n = 1'b0;
    wait_state(2'b11, 20, "step_state");
    check("step_clears_done", int'(done), 0);
    key_step_n = 1'b1;
    repeat (10) @(negedge clk);
    check("step_counter", int'(model_cnt), 4);

    // Load and run pressed together: load wins, run is dropped
    sw_d = 4'h5;
    push_exp(1'b0, 4'h5, 0, 1'b0);
    key_load_n = 1'b0;
    key_run_n  = 1'b0;
    wait_state(2'b10, 20, "sim_load_state");
    @(negedge clk);
    check("sim_back_idle", int'(state), 0);
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (state == 2'b01) bad++;
    end
    check("sim_no_run", bad, 0);
    key_load_n = 1'b1;
    key_run_n  = 1'b1;
    repeat (15) @(negedge clk);
    check("sim_counter", int'(model_cnt), 5);

    // Reset in the cycle before the first tick of a run
    sw_oneshot = 1'b1;
    sw_term = 4'h6;
    key_run_n = 1'b0;
    wait_state(2'b01, 20, "rr_run_state");
    key_run_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rr_state", int'(state), 0);
    check("rr_cnt_en", int'(cnt_en), 0);
    check("rr_done", int'(done), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rr_counter_kept", int'(model_cnt), 5);
    push_exp(1'b1, 4'h5, 4, 1'b1);
    key_run_n = 1'b0;
    wait_state(2'b01, 20, "rr_rerun_state");
    key_run_n = 1'b1;
    wait_state(2'b00, 30, "rr_stop_state");
    check("rr_done_after", int'(done), 1);
    check("rr_counter_after", int'(model_cnt), 6);
    repeat (10) @(negedge clk);
    check("final_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
